seg7_scan_mux: RTL and testbench

Four-digit multiplexed display scanner placed directly upstream of the `segment7` BCD-to-7-segment decoder. It holds a 16-bit BCD word and time-multiplexes one nibble at a time onto the decoder inputs. It drives active-low digit anodes in step with the nibble. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg7_scan_mux.sv | 112 +++++++++++
 tb/tb_seg7_scan_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Four-digit multiplexed display scanner that feeds a BCD-to-7-segment
// decoder. A 16-bit BCD word is shown one nibble at a time, with the
// active-low anodes stepped in lockstep. New words go into a shadow register
// and are committed to the displayed word only at a frame boundary. This means
// a frame never shows a mix of old and new digits.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   load       : single-cycle strobe, captures value into the shadow register
//   value      : BCD word, [3:0] is digit 0 (rightmost), [15:12] is digit 3
//   blank_lz   : when 1, leading-zero digits (other than digit 0) stay dark
//   digit      : nibble to the decoder ([3]->A ... [0]->D)
//   an         : active-low anode enables, an[i] = 0 lights digit i
//   frame_done : one-cycle pulse after every frame-boundary tick
module seg7_scan_mux #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PcW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PcW-1:0] PcMax = PcW'(CLK_DIV - 1);

    logic [PcW-1:0] pc_q, pc_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [15:0]    disp_q, disp_d;
    logic           pending_q, pending_d;
    logic [3:0]     digit_q, digit_d;
    logic [3:0]     an_q, an_d;
    logic           frameDone_q, frameDone_d;

    logic           tick;
    logic           boundary;
    logic [3:0]     leadZero;

    // Next-state logic. The displayed nibble and anode pattern are derived
    // from the post-update slot index and display word. This lets the first
    // slot of a new frame already show the freshly committed value.
    always_comb begin
        tick        = (pc_q == PcMax);
        boundary    = tick && (idx_q == 2'd3);

        pc_d        = tick ? '0 : pc_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        shadow_d    = load ? value : shadow_q;
        disp_d      = (boundary && pending_q) ? shadow_q : disp_q;

        // A load on the boundary cycle re-arms pending for the new value
        pending_d   = pending_q;
        if (load) begin
            pending_d = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end

        // leadZero[n]: every nibble from 3 down to n is zero (digit 0 exempt)
        leadZero[3] = (disp_d[15:12] == 4'h0);
        leadZero[2] = leadZero[3] && (disp_d[11:8] == 4'h0);
        leadZero[1] = leadZero[2] && (disp_d[7:4] == 4'h0);
        leadZero[0] = 1'b0;

        digit_d     = digit_q;
        an_d        = an_q;
        frameDone_d = 1'b0;
        if (tick) begin
            digit_d     = disp_d[{idx_d, 2'b00} +: 4];
            an_d        = 4'b1111;
            if (!(blank_lz && leadZero[idx_d])) begin
                an_d[idx_d] = 1'b0;
            end
            frameDone_d = boundary;
        end
    end

    // idx resets to 3 so that the first tick after reset is a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            idx_q       <= 2'd3;
            shadow_q    <= 16'h0000;
            disp_q      <= 16'h0000;
            pending_q   <= 1'b0;
            digit_q     <= 4'h0;
            an_q        <= 4'b1111;
            frameDone_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            digit_q     <= digit_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign digit      = digit_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux
// Directed testbench for seg7_scan_mux with CLK_DIV = 4.
// The bench has a frame-level reference model. It counts the clock edges since
// reset and uses that count to work out the current slot and the frame start.
// The word on display is the most recent load captured strictly before that
// frame boundary. A compare process checks every cycle against the model. A set
// of hand-computed literal checks pins the model at key moments.
module tb_seg7_scan_mux;

    localparam int C = 4;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_done;

    int passCount  = 0;
    int checkCount = 0;
    bit checkEn    = 1'b0;

    // Reference model state
    int          modelK   = 0;
    bit          tickBlank = 1'b0;
    int          loadEdge[$];
    logic [15:0] loadVal[$];

    seg7_scan_mux #(.CLK_DIV(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .digit      (digit),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (k=%0d): got %h, expected %h", name, modelK, act, exp);
        end
    endtask

    // Word displayed in the frame that began at boundary edge b
    function automatic logic [15:0] wordBefore(input int b);
        for (int i = loadEdge.size() - 1; i >= 0; i--) begin
            if (loadEdge[i] < b) return loadVal[i];
        end
        return 16'h0000;
    endfunction

    // Model update at every rising edge, using the inputs as the DUT sees them
    always @(posedge clk) begin
        if (rst) begin
            modelK = 0;
            loadEdge.delete();
            loadVal.delete();
            tickBlank = 1'b0;
        end else begin
            modelK++;
            if (load) begin
                loadEdge.push_back(modelK);
                loadVal.push_back(value);
            end
            if (modelK % C == 0) tickBlank = blank_lz;
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (checkEn) begin
            logic [3:0]  expAn;
            logic [3:0]  expDigit;
            logic        expFd;
            int          t, n, b;
            logic [15:0] w;
            if (modelK < C) begin
                expAn    = 4'b1111;
                expDigit = 4'h0;
                expFd    = 1'b0;
            end else begin
                t        = (modelK / C) * C;
                n        = ((t / C) - 1) % 4;
                b        = t - n * C;
                w        = wordBefore(b);
                expDigit = 4'((w >> (4 * n)) & 16'hF);
                expFd    = (modelK == t) && (n == 0);
                expAn    = 4'b1111;
                if (!(tickBlank && n != 0 && (w >> (4 * n)) == 0)) expAn[n] = 1'b0;
            end
            checkOutput("model_an", 16'(an), 16'(expAn));
            checkOutput("model_digit", 16'(digit), 16'(expDigit));
            checkOutput("model_frame_done", 16'(frame_done), 16'(expFd));
        end
    end

    task automatic goToK(input int target);
        int guard = 0;
        while (modelK < target && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (modelK != target) begin
            checkCount++;
            $display("[TB] FAIL goToK: got k=%0d, expected %0d", modelK, target);
        end
    endtask

    task automatic applyStimulus(input int atK, input logic [15:0] v);
        goToK(atK - 1);
        load  = 1'b1;
        value = v;
        goToK(atK);
        load  = 1'b0;
    endtask

    task automatic pin(input string name, input logic [3:0] expAn, input logic [3:0] expDigit,
                       input logic expFd);
        checkOutput({name, "_an"}, 16'(an), 16'(expAn));
        checkOutput({name, "_digit"}, 16'(digit), 16'(expDigit));
        checkOutput({name, "_fd"}, 16'(frame_done), 16'(expFd));
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pin("in_reset", 4'b1111, 4'h0, 1'b0);
        rst = 1'b0;

        // Reset release: dark for C cycles, then the first frame boundary
        goToK(3);   pin("pre_tick", 4'b1111, 4'h0, 1'b0);
        goToK(4);   pin("first_tick", 4'b1110, 4'h0, 1'b1);
        goToK(5);   pin("fd_drop", 4'b1110, 4'h0, 1'b0);

        // Mid-frame load commits at the next boundary
        applyStimulus(6, 16'h1234);
        goToK(19);  pin("old_frame", 4'b0111, 4'h0, 1'b0);
        goToK(20);  pin("d0_1234", 4'b1110, 4'h4, 1'b1);
        applyStimulus(22, 16'h1111);
        goToK(24);  pin("d1_1234", 4'b1101, 4'h3, 1'b0);
        goToK(28);  pin("d2_1234", 4'b1011, 4'h2, 1'b0);
        applyStimulus(30, 16'h5678);
        goToK(32);  pin("d3_1234", 4'b0111, 4'h1, 1'b0);
        goToK(36);  pin("d0_5678", 4'b1110, 4'h8, 1'b1);
        goToK(40);  pin("d1_5678", 4'b1101, 4'h7, 1'b0);

        // Load on the exact boundary cycle while another value is pending
        applyStimulus(45, 16'h1234);
        applyStimulus(52, 16'h9999);
        pin("boundary_old", 4'b1110, 4'h4, 1'b1);
        goToK(68);  pin("boundary_new", 4'b1110, 4'h9, 1'b1);

        // Leading-zero blanking
        goToK(69);
        blank_lz = 1'b1;
        applyStimulus(70, 16'h0050);
        goToK(72);  pin("noblank_9999", 4'b1101, 4'h9, 1'b0);
        goToK(84);  pin("lz_d0", 4'b1110, 4'h0, 1'b1);
        goToK(88);  pin("lz_d1", 4'b1101, 4'h5, 1'b0);
        applyStimulus(90, 16'h0000);
        goToK(92);  pin("lz_d2", 4'b1111, 4'h0, 1'b0);
        goToK(96);  pin("lz_d3", 4'b1111, 4'h0, 1'b0);
        goToK(100); pin("zero_d0", 4'b1110, 4'h0, 1'b1);
        goToK(104); pin("zero_d1", 4'b1111, 4'h0, 1'b0);

        // Non-BCD nibbles pass through
        goToK(113);
        blank_lz = 1'b0;
        applyStimulus(115, 16'hABCD);
        goToK(116); pin("hex_d0", 4'b1110, 4'hD, 1'b1);
        goToK(120); pin("hex_d1", 4'b1101, 4'hC, 1'b0);

        // Reset during slot 2 with a value pending
        applyStimulus(122, 16'h1357);
        goToK(124); pin("hex_d2", 4'b1011, 4'hB, 1'b0);
        goToK(125);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pin("mid_reset", 4'b1111, 4'h0, 1'b0);
        rst = 1'b0;
        goToK(3);   pin("post_rst_dark", 4'b1111, 4'h0, 1'b0);
        goToK(4);   pin("post_rst_tick", 4'b1110, 4'h0, 1'b1);
        goToK(8);   pin("post_rst_d1", 4'b1101, 4'h0, 1'b0);
        goToK(20);  pin("discarded", 4'b1110, 4'h0, 1'b1);

        @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
